// File: rtl/seq_divider_32bit.sv
// seq_divider_32bit: multi-cycle unsigned restoring divider used as the ALU divide unit.
// One quotient bit per clock, MSB first; results hold until the next accepted start.
module seq_divider_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;

  // Trial subtraction for one restoring step.
  // The partial remainder is always below the divisor, so it fits in WIDTH
  // bits between iterations; the extra bit lives only in the shifted/trial
  // values, where it acts as the borrow that decides the quotient bit.
  always_comb begin
    w_shift  = {r_r, r_q[WIDTH-1]};
    w_trial  = w_shift - {1'b0, r_d};
    w_fits   = ~w_trial[WIDTH];
    w_r_next = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_q_next = {r_q[WIDTH-2:0], w_fits};
    w_last   = (r_cnt == CW'(WIDTH - 1));
  end

  // Control FSM with all datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              r_q     <= dividend;
              r_r     <= '0;
              r_d     <= divisor;
              r_cnt   <= '0;
              r_dbz   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= RUN;
            end else begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= FIN;
            end
          end
        end
        RUN: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= FIN;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Self-checking bench for seq_divider_32bit: directed cases plus random
// operands against plain / and % arithmetic.
module tb_seq_divider_32bit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  seq_divider_32bit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count, used to measure done spacing.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference results from plain arithmetic.
  function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // Start one operation from IDLE; report cycles from accept to done and busy cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cycles);
    bit seen;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 0; busy_cycles = 0; seen = 0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      if (busy) busy_cycles++;
      if (done) begin
        lat  = k;
        seen = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    int bcyc;
    int pulses;
    int last_done;
    bit seen;
    logic [31:0] ea;
    logic [31:0] eb;

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    @(negedge clk);

    // 100 / 7
    run_op(32'd100, 32'd7, lat, bcyc);
    check("lat_100_7", lat, 33);
    check("q_100_7", quotient, 14);
    check("r_100_7", remainder, 2);
    check("dbz_100_7", div_by_zero, 0);
    check("busy_100_7", bcyc, 32);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // Extremes
    run_op(32'hFFFF_FFFF, 32'd1, lat, bcyc);
    check("q_max_1", quotient, 32'hFFFF_FFFF);
    check("r_max_1", remainder, 0);
    run_op(32'd5, 32'hFFFF_FFFF, lat, bcyc);
    check("q_5_max", quotient, 0);
    check("r_5_max", remainder, 5);

    // Divide by zero
    run_op(32'd1234, 32'd0, lat, bcyc);
    check("lat_dbz", lat, 1);
    check("q_dbz", quotient, 32'hFFFF_FFFF);
    check("r_dbz", remainder, 1234);
    check("flag_dbz", div_by_zero, 1);
    check("busy_dbz", bcyc, 0);

    // Start during RUN is ignored; outputs hold during RUN
    @(negedge clk);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_mid_run", busy, 1);
    check("q_hold_run", quotient, 32'hFFFF_FFFF);
    check("r_hold_run", remainder, 1234);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("pulses_ignore", pulses, 1);
    check("q_1000_10", quotient, 100);
    check("r_1000_10", remainder, 0);
    check("dbz_1000_10", div_by_zero, 0);

    // Reset mid-operation aborts with no done pulse
    @(negedge clk);
    start = 1'b1; dividend = 32'h8000_0000; divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dbz", div_by_zero, 0);
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", pulses, 0);
    run_op(32'h8000_0000, 32'd3, lat, bcyc);
    check("lat_after_abort", lat, 33);
    check("q_after_abort", quotient, 32'h2AAA_AAAA);
    check("r_after_abort", remainder, 2);

    // Random back-to-back with start held high
    @(negedge clk);
    @(negedge clk);
    ea = $urandom >> $urandom_range(0, 31);
    eb = $urandom >> $urandom_range(0, 31);
    if (eb == 0) eb = 32'd1;
    dividend = ea; divisor = eb; start = 1'b1;
    last_done = -1;
    for (int n = 0; n < 2000; n++) begin
      seen = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      if (!seen) begin
        check("rand_timeout", 64'd0, 64'd1);
        break;
      end
      check("rand_q", quotient, ref_q(ea, eb));
      check("rand_r", remainder, ref_r(ea, eb));
      if (last_done >= 0) check("rand_spacing", cycle - last_done, 34);
      last_done = cycle;
      ea = $urandom >> $urandom_range(0, 31);
      eb = $urandom >> $urandom_range(0, 31);
      if (eb == 0) eb = 32'd1;
      dividend = ea; divisor = eb;
    end
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
